// File: rtl/mac_pkg.sv
// Shared definitions for the mac_unit memory server.
// Holds the server FSM state type and the default address widths for the
// 4x4x4 configuration.
package mac_pkg;

  localparam int unsigned MAC_M = 4;
  localparam int unsigned MAC_K = 4;
  localparam int unsigned MAC_N = 4;

  localparam int unsigned A_AW = $clog2(MAC_M * MAC_K);
  localparam int unsigned B_AW = $clog2(MAC_K * MAC_N);
  localparam int unsigned C_AW = $clog2(MAC_M * MAC_N);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StStart,
    StRun,
    StDrain
  } mac_srv_state_t;

endpackage

// File: rtl/mac_sync_ram.sv
// Single-port-write / single-port-read RAM with a registered read.
// Ports:
//   clk, rstn        clock and asynchronous active-low reset (read register only)
//   we_i, waddr_i,
//   wdata_i          synchronous write
//   re_i, raddr_i    read enable and address; rdata_o updates after the edge
//   rdata_o          read data, holds its value while re_i is low
module mac_sync_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/mac_mem_server.sv
// Memory-side partner of mac_unit: stores A (MxK) and transposed B (NxK),
// collects C (MxN) and sequences load -> start -> run -> drain.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   a_b_re, a_addr_out, b_addr_out mac_unit read request (honoured in RUN only)
//   a_data_in, b_data_in           registered read data to mac_unit
//   c_we, c_addr_out, c_data_out   mac_unit C write (honoured in RUN only)
//   mac_start, mac_done            job start pulse / job complete
//   host_in_*                      A-then-B byte load stream
//   host_out_*                     C readback stream, last on final word
//   busy                           high whenever not idle
module mac_mem_server
  import mac_pkg::*;
#(
  parameter int unsigned param_M            = 4,
  parameter int unsigned param_K            = 4,
  parameter int unsigned param_N            = 4,
  parameter int unsigned DATA_WIDTH_INITIAL = 8,
  parameter int unsigned DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  a_b_re,
  input  logic [$clog2(param_M*param_K)-1:0]    a_addr_out,
  input  logic [$clog2(param_K*param_N)-1:0]    b_addr_out,
  output logic [DATA_WIDTH_INITIAL-1:0]         a_data_in,
  output logic [DATA_WIDTH_INITIAL-1:0]         b_data_in,
  input  logic                                  c_we,
  input  logic [$clog2(param_M*param_N)-1:0]    c_addr_out,
  input  logic [DATA_WIDTH_FINAL-1:0]           c_data_out,
  output logic                                  mac_start,
  input  logic                                  mac_done,
  input  logic                                  host_in_valid,
  output logic                                  host_in_ready,
  input  logic [DATA_WIDTH_INITIAL-1:0]         host_in_data,
  output logic                                  host_out_valid,
  input  logic                                  host_out_ready,
  output logic [DATA_WIDTH_FINAL-1:0]           host_out_data,
  output logic                                  host_out_last,
  output logic                                  busy
);

  localparam int unsigned SizeA = param_M * param_K;
  localparam int unsigned SizeB = param_K * param_N;
  localparam int unsigned SizeC = param_M * param_N;
  localparam int unsigned AAw   = $clog2(SizeA);
  localparam int unsigned BAw   = $clog2(SizeB);
  localparam int unsigned CAw   = $clog2(SizeC);
  localparam int unsigned LdW   = $clog2(SizeA + 1);
  localparam int unsigned RowW  = $clog2(param_K + 1);
  localparam int unsigned ColW  = $clog2(param_N + 1);
  localparam int unsigned DrW   = $clog2(SizeC + 1);

  mac_srv_state_t  state_q, state_d;
  logic [LdW-1:0]  ld_cnt_q, ld_cnt_d;
  logic [RowW-1:0] b_row_q, b_row_d;
  logic [ColW-1:0] b_col_q, b_col_d;
  logic [DrW-1:0]  rd_cnt_q, rd_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;

  logic            a_we, b_we, ab_re, c_wr, c_re, out_fire;
  logic [AAw-1:0]  a_waddr;
  logic [BAw-1:0]  b_waddr;
  logic [CAw-1:0]  c_raddr;

  assign ab_re    = a_b_re & (state_q == StRun);
  assign c_wr     = c_we & (state_q == StRun);
  assign a_waddr  = AAw'(ld_cnt_q);
  // Stream beat (row, col) of B lands at col*K + row: transpose on load.
  assign b_waddr  = BAw'(b_col_q * param_K + b_row_q);
  assign c_raddr  = CAw'(rd_cnt_q);
  assign out_fire = out_valid_q & host_out_ready;

  assign busy           = (state_q != StIdle);
  assign host_out_valid = out_valid_q;
  assign host_out_last  = out_last_q;

  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    b_row_d       = b_row_q;
    b_col_d       = b_col_q;
    rd_cnt_d      = rd_cnt_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    host_in_ready = 1'b0;
    mac_start     = 1'b0;
    a_we          = 1'b0;
    b_we          = 1'b0;
    c_re          = 1'b0;

    unique case (state_q)
      // IDLE behaves as LOAD_A with the count at zero.
      StIdle, StLoadA: begin
        host_in_ready = 1'b1;
        if (host_in_valid) begin
          a_we = 1'b1;
          if (ld_cnt_q == LdW'(SizeA - 1)) begin
            ld_cnt_d = '0;
            state_d  = StLoadB;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
            state_d  = StLoadA;
          end
        end
      end
      StLoadB: begin
        host_in_ready = 1'b1;
        if (host_in_valid) begin
          b_we = 1'b1;
          if (b_col_q == ColW'(param_N - 1)) begin
            b_col_d = '0;
            if (b_row_q == RowW'(param_K - 1)) begin
              b_row_d = '0;
              state_d = StStart;
            end else begin
              b_row_d = b_row_q + 1'b1;
            end
          end else begin
            b_col_d = b_col_q + 1'b1;
          end
        end
      end
      StStart: begin
        mac_start = 1'b1;
        state_d   = StRun;
      end
      StRun: begin
        if (mac_done) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // The C RAM output register is the one-entry skid: only fetch the next
        // word when the current one is empty or leaving this cycle.
        c_re = (rd_cnt_q < DrW'(SizeC)) & (~out_valid_q | host_out_ready);
        if (c_re) begin
          out_valid_d = 1'b1;
          out_last_d  = (rd_cnt_q == DrW'(SizeC - 1));
          rd_cnt_d    = rd_cnt_q + 1'b1;
        end else if (out_fire) begin
          out_valid_d = 1'b0;
        end
        if (out_fire && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rd_cnt_d    = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      ld_cnt_q    <= '0;
      b_row_q     <= '0;
      b_col_q     <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      b_row_q     <= b_row_d;
      b_col_q     <= b_col_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  mac_sync_ram #(.DEPTH(SizeA), .WIDTH(DATA_WIDTH_INITIAL)) u_ram_a (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (a_we),
    .waddr_i (a_waddr),
    .wdata_i (host_in_data),
    .re_i    (ab_re),
    .raddr_i (a_addr_out),
    .rdata_o (a_data_in)
  );

  mac_sync_ram #(.DEPTH(SizeB), .WIDTH(DATA_WIDTH_INITIAL)) u_ram_b (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (b_we),
    .waddr_i (b_waddr),
    .wdata_i (host_in_data),
    .re_i    (ab_re),
    .raddr_i (b_addr_out),
    .rdata_o (b_data_in)
  );

  mac_sync_ram #(.DEPTH(SizeC), .WIDTH(DATA_WIDTH_FINAL)) u_ram_c (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (c_wr),
    .waddr_i (c_addr_out),
    .wdata_i (c_data_out),
    .re_i    (c_re),
    .raddr_i (c_raddr),
    .rdata_o (host_out_data)
  );

endmodule

// File: tb/tb_mac_mem_server.sv
module tb_mac_mem_server;

  localparam int M = 4, K = 4, N = 4;
  localparam int MK = M * K, KN = K * N, MN = M * N;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        a_b_re = 1'b0;
  logic [3:0]  a_addr_out = '0;
  logic [3:0]  b_addr_out = '0;
  logic [7:0]  a_data_in, b_data_in;
  logic        c_we = 1'b0;
  logic [3:0]  c_addr_out = '0;
  logic [15:0] c_data_out = '0;
  logic        mac_start;
  logic        mac_done = 1'b0;
  logic        host_in_valid = 1'b0;
  logic        host_in_ready;
  logic [7:0]  host_in_data = '0;
  logic        host_out_valid;
  logic        host_out_ready = 1'b0;
  logic [15:0] host_out_data;
  logic        host_out_last;
  logic        busy;

  always #5 clk = ~clk;

  mac_mem_server #(
    .param_M(M), .param_K(K), .param_N(N),
    .DATA_WIDTH_INITIAL(8), .DATA_WIDTH_FINAL(16)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .a_b_re         (a_b_re),
    .a_addr_out     (a_addr_out),
    .b_addr_out     (b_addr_out),
    .a_data_in      (a_data_in),
    .b_data_in      (b_data_in),
    .c_we           (c_we),
    .c_addr_out     (c_addr_out),
    .c_data_out     (c_data_out),
    .mac_start      (mac_start),
    .mac_done       (mac_done),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_in_data   (host_in_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_out_data  (host_out_data),
    .host_out_last  (host_out_last),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 loading A, 2 loading B, 3 start, 4 run, 5 drain.
  int          m_phase = 0;
  int          m_n = 0;
  int          m_didx = 0;
  logic [7:0]  m_a [MK];
  logic [7:0]  m_b [KN];
  logic [15:0] m_c [MN];
  logic [7:0]  m_exp_a = '0;
  logic [7:0]  m_exp_b = '0;
  logic        hs_q = 1'b0;
  logic        stall_q = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= 0;
      m_n     <= 0;
      m_didx  <= 0;
      m_exp_a <= '0;
      m_exp_b <= '0;
    end else begin
      case (m_phase)
        0, 1: if (host_in_valid) begin
          m_a[m_n] <= host_in_data;
          if (m_n == MK - 1) begin m_phase <= 2; m_n <= 0; end
          else begin m_phase <= 1; m_n <= m_n + 1; end
        end
        2: if (host_in_valid) begin
          // beat n = i*N + j goes to Btr[j*K + i]
          m_b[(m_n % N) * K + m_n / N] <= host_in_data;
          if (m_n == KN - 1) begin m_phase <= 3; m_n <= 0; end
          else m_n <= m_n + 1;
        end
        3: m_phase <= 4;
        4: begin
          if (a_b_re) begin
            m_exp_a <= m_a[a_addr_out];
            m_exp_b <= m_b[b_addr_out];
          end
          if (c_we) m_c[c_addr_out] <= c_data_out;
          if (mac_done) begin m_phase <= 5; m_didx <= 0; end
        end
        5: if (hs_q) begin
          if (m_didx == MN - 1) begin m_phase <= 0; m_didx <= 0; end
          else m_didx <= m_didx + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_in_ready", host_in_ready, 1);
      chk("rst_mac_start", mac_start, 0);
      chk("rst_a_data", a_data_in, 0);
      chk("rst_b_data", b_data_in, 0);
      chk("rst_out_valid", host_out_valid, 0);
      chk("rst_out_data", host_out_data, 0);
      chk("rst_out_last", host_out_last, 0);
      chk("rst_busy", busy, 0);
      hs_q    <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      chk("in_ready", host_in_ready, m_phase <= 2);
      chk("busy", busy, m_phase != 0);
      chk("mac_start", mac_start, m_phase == 3);
      chk("a_data", a_data_in, m_exp_a);
      chk("b_data", b_data_in, m_exp_b);
      if (stall_q) chk("out_valid_hold", host_out_valid, 1);
      if (host_out_valid) begin
        chk("out_in_drain", m_phase, 5);
        chk("out_data", host_out_data, m_c[m_didx]);
        chk("out_last", host_out_last, m_didx == MN - 1);
      end
      hs_q    <= host_out_valid & host_out_ready;
      stall_q <= host_out_valid & ~host_out_ready;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0]  a_src [MK];
  logic [7:0]  b_src [KN];
  logic [15:0] drained [MN];
  logic        last_seen [MN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int golden(input int i, input int j);
    int s = 0;
    for (int k = 0; k < K; k++) s += int'(a_src[i * K + k]) * int'(b_src[k * N + j]);
    return s;
  endfunction

  task automatic load_beats(input int first, input int last_ex, input bit gaps);
    for (int i = first; i < last_ex; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        host_in_valid = 1'b0;
        tick();
      end
      host_in_valid = 1'b1;
      host_in_data  = (i < MK) ? a_src[i] : b_src[i - MK];
      tick();
    end
    host_in_valid = 1'b0;
  endtask

  // Plays mac_unit: dot products through the read port, C writes, then done.
  task automatic run_stub(input bit skip0);
    for (int c = 0; c < MN; c++) begin
      int acc = 0;
      for (int k = 0; k < K; k++) begin
        a_b_re     = 1'b1;
        a_addr_out = 4'((c / N) * K + k);
        b_addr_out = 4'((c % N) * K + k);
        tick();
        acc += int'(a_data_in) * int'(b_data_in);
      end
      chk("dot_product", acc, golden(c / N, c % N));
      a_b_re     = 1'($urandom_range(0, 1));
      a_addr_out = 4'($urandom_range(0, 15));
      b_addr_out = 4'($urandom_range(0, 15));
      tick();
      a_b_re = 1'b0;
      if (!(skip0 && c == 0)) begin
        c_we       = 1'b1;
        c_addr_out = 4'(c);
        c_data_out = 16'(acc);
        mac_done   = (c == MN - 1);
        tick();
        c_we     = 1'b0;
        mac_done = 1'b0;
      end
    end
    chk("valid_low_after_done", host_out_valid, 0);
    tick();
    chk("valid_rise", host_out_valid, 1);
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic drain(input int mode);
    int got = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
    while (got < MN && cyc < 400) begin
      case (mode)
        0: host_out_ready = 1'b1;
        1: host_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: host_out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (host_out_valid && host_out_ready) begin
        drained[got]   = host_out_data;
        last_seen[got] = host_out_last;
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    host_out_ready = 1'b0;
    chk("drain_count", got, MN);
    if (mode == 0) chk("drain_rate", last_cyc - first_cyc, MN - 1);
    for (int k = 0; k < got; k++) begin
      chk("drain_order", drained[k], m_c[k]);
      chk("drain_last_flag", last_seen[k], k == MN - 1);
    end
    chk("idle_after_drain", busy, 0);
  endtask

  task automatic ramp_src();
    for (int i = 0; i < MK; i++) a_src[i] = 8'(i);
    for (int i = 0; i < KN; i++) b_src[i] = 8'(i);
  endtask

  task automatic full_job(input bit gaps, input bit skip0, input int mode);
    load_beats(0, MK + KN, gaps);
    chk("start_after_load", mac_start, 1);
    tick();
    chk("start_one_cycle", mac_start, 0);
    run_stub(skip0);
    drain(mode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Basic 4x4 job with ramp data.
    ramp_src();
    full_job(1'b0, 1'b0, 0);
    chk("c0_basic", drained[0], 56);
    chk("c5_basic", drained[5], 174);
    chk("c15_basic", drained[15], 506);

    // Transpose, read hold and input gating inside RUN.
    load_beats(0, MK + KN, 1'b0);
    chk("start_after_load2", mac_start, 1);
    tick();
    a_b_re = 1'b1; a_addr_out = 4'd1; b_addr_out = 4'd1;
    tick();
    chk("btr_1", b_data_in, 4);
    chk("a_1", a_data_in, 1);
    b_addr_out = 4'd4;
    tick();
    chk("btr_4", b_data_in, 1);
    a_addr_out = 4'd3;
    tick();
    chk("a_3", a_data_in, 3);
    a_b_re = 1'b0; a_addr_out = 4'd7;
    tick();
    chk("a_hold_1", a_data_in, 3);
    tick();
    chk("a_hold_2", a_data_in, 3);
    host_in_valid = 1'b1; host_in_data = 8'hAA;
    chk("ready_low_in_run", host_in_ready, 0);
    tick();
    host_in_valid = 1'b0;
    a_b_re = 1'b1; a_addr_out = 4'd0;
    tick();
    a_b_re = 1'b0;
    chk("a0_unchanged", a_data_in, 0);
    run_stub(1'b0);
    drain(1);

    // C write while idle must not land; skipped C[0] drains stale 56.
    c_we = 1'b1; c_addr_out = 4'd0; c_data_out = 16'hBEEF;
    tick();
    c_we = 1'b0;
    for (int i = 0; i < MK; i++) a_src[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < KN; i++) b_src[i] = 8'($urandom_range(0, 255));
    load_beats(0, 5, 1'b0);
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    chk("done_ignored_in_load", busy, 1);
    load_beats(5, MK + KN, 1'b0);
    chk("start_after_load3", mac_start, 1);
    tick();
    run_stub(1'b1);
    drain(2);
    chk("c0_stale", drained[0], 56);

    // Reset in the middle of LOAD_B, then a full reload.
    ramp_src();
    load_beats(0, MK + 3, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", host_in_ready, 1);
    chk("midrst_a_data", a_data_in, 0);
    tick();
    rstn = 1'b1;
    tick();
    full_job(1'b0, 1'b0, 0);
    chk("c0_after_reset", drained[0], 56);

    // Randomized jobs.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < MK; i++) a_src[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < KN; i++) b_src[i] = 8'($urandom_range(0, 255));
      full_job(1'b1, r == 1, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
